// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, state type and parameter legality for the I2S transmitter
package i2s_pkg;

    localparam int I2S_MODE_I2S = 0;
    localparam int I2S_MODE_LJ  = 1;

    localparam int I2S_DATA_W_MIN = 8;
    localparam int I2S_DATA_W_MAX = 32;
    localparam int I2S_NUM_CH_MIN = 2;
    localparam int I2S_NUM_CH_MAX = 8;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_ARM,
        TX_RUN
    } tx_state_e;

    function automatic bit i2s_params_ok(input int data_w, input int slot_w, input int num_ch,
                                         input int fifo_depth, input int mode,
                                         input int mclk_half, input int bclk_half);
        return (data_w >= I2S_DATA_W_MIN) && (data_w <= I2S_DATA_W_MAX) &&
               (slot_w >= data_w) &&
               (num_ch >= I2S_NUM_CH_MIN) && (num_ch <= I2S_NUM_CH_MAX) && (num_ch % 2 == 0) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
               ((mode == I2S_MODE_I2S) || (mode == I2S_MODE_LJ)) &&
               (mclk_half >= 1) && (bclk_half >= 1);
    endfunction

endpackage

// File: rtl/i2s_frame_fifo.sv
// rtl/i2s_frame_fifo.sv - synchronous frame FIFO with registered ready and level
module i2s_frame_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     ready,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level_nxt;
    logic             do_push;
    logic             do_pop;

    // ready is the registered not-full flag, so a same-cycle pop never frees a slot early
    assign do_push = push && ready;
    assign do_pop  = pop && !empty;
    assign empty   = (level == '0);
    assign rd_data = mem[rd_ptr];

    always_comb begin
        level_nxt = level;
        if (do_push && !do_pop) begin
            level_nxt = level + (AW+1)'(1);
        end else if (do_pop && !do_push) begin
            level_nxt = level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ready  <= 1'b1;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level_nxt;
            ready <= (level_nxt != (AW+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/i2s_tx_multi.sv
// rtl/i2s_tx_multi.sv - multi-channel I2S / left-justified transmitter with clock generation
module i2s_tx_multi
    import i2s_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int SLOT_W     = 32,
    parameter int NUM_CH     = 2,
    parameter int MCLK_HALF  = 1,
    parameter int BCLK_HALF  = 4,
    parameter int MODE       = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_en,
    input  logic                          i_mute,
    input  logic                          i_valid,
    output logic                          o_ready,
    input  logic [NUM_CH*DATA_W-1:0]      i_data,
    output logic                          o_mclk,
    output logic                          o_bclk,
    output logic                          o_lrclk,
    output logic                          o_sdin,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
    output logic [7:0]                    o_underrun_cnt
);
    localparam int FRAME_BITS = NUM_CH * SLOT_W;
    localparam int BW = $clog2(FRAME_BITS);
    localparam int MW = $clog2(MCLK_HALF) + 1;
    localparam int DW = $clog2(BCLK_HALF) + 1;
    localparam bit PARAMS_OK = i2s_params_ok(DATA_W, SLOT_W, NUM_CH, FIFO_DEPTH, MODE,
                                             MCLK_HALF, BCLK_HALF);

    if (!PARAMS_OK) begin : g_bad_params
        $error("i2s_tx_multi: illegal parameter combination");
    end

    tx_state_e                state;
    tx_state_e                state_nxt;
    logic [MW-1:0]            mclk_div;
    logic [DW-1:0]            bclk_div;
    logic [BW-1:0]            bit_cnt;
    logic [BW-1:0]            bit_nxt;
    logic [FRAME_BITS-1:0]    sreg;
    logic [FRAME_BITS-1:0]    stream;
    logic [FRAME_BITS-1:0]    shift_src;
    logic [NUM_CH*DATA_W-1:0] fifo_data;
    logic                     fifo_empty;
    logic                     bclk_tc;
    logic                     fall;
    logic                     load;

    i2s_frame_fifo #(
        .WIDTH (NUM_CH*DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (i_valid),
        .wr_data (i_data),
        .pop     (load),
        .rd_data (fifo_data),
        .ready   (o_ready),
        .empty   (fifo_empty),
        .level   (o_fifo_level)
    );

    // Slot k of the frame stream holds channel k MSB-first, left-aligned, zero padded
    always_comb begin
        stream = '0;
        if (!fifo_empty) begin
            for (int ch = 0; ch < NUM_CH; ch++) begin
                stream[FRAME_BITS-1-ch*SLOT_W -: SLOT_W] =
                    SLOT_W'(fifo_data[ch*DATA_W +: DATA_W]) << (SLOT_W - DATA_W);
            end
        end
    end

    assign bclk_tc   = (bclk_div == DW'(BCLK_HALF - 1));
    assign fall      = i_en && bclk_tc && o_bclk;
    assign shift_src = load ? stream : sreg;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= TX_IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE: state_nxt = TX_ARM;
            TX_ARM:  if (fall) state_nxt = TX_RUN;
            default: state_nxt = state;
        endcase
        if (!i_en) state_nxt = TX_IDLE;
    end

    // A frame starts at the first falling edge after enable and at every bit counter wrap
    always_comb begin
        load    = 1'b0;
        bit_nxt = bit_cnt;
        if (fall) begin
            if (state != TX_RUN || bit_cnt == BW'(FRAME_BITS - 1)) begin
                load    = 1'b1;
                bit_nxt = '0;
            end else begin
                bit_nxt = bit_cnt + BW'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mclk_div <= '0;
            o_mclk   <= 1'b0;
        end else if (mclk_div == MW'(MCLK_HALF - 1)) begin
            mclk_div <= '0;
            o_mclk   <= ~o_mclk;
        end else begin
            mclk_div <= mclk_div + MW'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bclk_div <= '0;
            o_bclk   <= 1'b0;
            o_lrclk  <= 1'b0;
            o_sdin   <= 1'b0;
            bit_cnt  <= '0;
            sreg     <= '0;
        end else if (!i_en) begin
            bclk_div <= '0;
            o_bclk   <= 1'b0;
            o_lrclk  <= 1'b0;
            o_sdin   <= 1'b0;
            bit_cnt  <= '0;
            sreg     <= '0;
        end else begin
            if (bclk_tc) begin
                bclk_div <= '0;
                o_bclk   <= ~o_bclk;
            end else begin
                bclk_div <= bclk_div + DW'(1);
            end
            if (fall) begin
                bit_cnt <= bit_nxt;
                o_lrclk <= (bit_nxt >= BW'(FRAME_BITS / 2));
                // I2S lags the stream by one bit, so the old frame's last bit leads the new one
                if (MODE == I2S_MODE_LJ) begin
                    o_sdin <= ~i_mute & shift_src[FRAME_BITS-1];
                    sreg   <= shift_src << 1;
                end else begin
                    o_sdin <= ~i_mute & sreg[FRAME_BITS-1];
                    sreg   <= load ? stream : (sreg << 1);
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_underrun_cnt <= '0;
        end else if (load && fifo_empty && o_underrun_cnt != 8'hFF) begin
            o_underrun_cnt <= o_underrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_i2s_tx_multi.sv
// tb/tb_i2s_tx_multi.sv - directed self-checking bench for i2s_tx_multi
module tb_i2s_tx_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        en_a, mute_a, valid_a, ready_a, mclk_a, bclk_a, lrclk_a, sdin_a;
    logic [31:0] data_a;
    logic [2:0]  level_a;
    logic [7:0]  urun_a;

    logic        en_b, mute_b, valid_b, ready_b, mclk_b, bclk_b, lrclk_b, sdin_b;
    logic [31:0] data_b;
    logic [2:0]  level_b;
    logic [7:0]  urun_b;

    logic        en_c, mute_c, valid_c, ready_c, mclk_c, bclk_c, lrclk_c, sdin_c;
    logic [63:0] data_c;
    logic [2:0]  level_c;
    logic [7:0]  urun_c;

    int n_checks = 0;
    int n_pass   = 0;
    int sel      = 0;

    logic         obs_bclk, obs_lrclk, obs_sdin;
    logic [255:0] cap_sd, cap_lr;

    i2s_tx_multi #(.MODE(0)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_a), .i_mute(mute_a), .i_valid(valid_a),
        .o_ready(ready_a), .i_data(data_a), .o_mclk(mclk_a), .o_bclk(bclk_a),
        .o_lrclk(lrclk_a), .o_sdin(sdin_a), .o_fifo_level(level_a), .o_underrun_cnt(urun_a)
    );

    i2s_tx_multi #(.MODE(1), .BCLK_HALF(1)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_b), .i_mute(mute_b), .i_valid(valid_b),
        .o_ready(ready_b), .i_data(data_b), .o_mclk(mclk_b), .o_bclk(bclk_b),
        .o_lrclk(lrclk_b), .o_sdin(sdin_b), .o_fifo_level(level_b), .o_underrun_cnt(urun_b)
    );

    i2s_tx_multi #(.NUM_CH(4), .SLOT_W(16), .DATA_W(16), .MODE(0), .BCLK_HALF(1)) dut_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_en(en_c), .i_mute(mute_c), .i_valid(valid_c),
        .o_ready(ready_c), .i_data(data_c), .o_mclk(mclk_c), .o_bclk(bclk_c),
        .o_lrclk(lrclk_c), .o_sdin(sdin_c), .o_fifo_level(level_c), .o_underrun_cnt(urun_c)
    );

    always_comb begin
        case (sel)
            1:       {obs_bclk, obs_lrclk, obs_sdin} = {bclk_b, lrclk_b, sdin_b};
            2:       {obs_bclk, obs_lrclk, obs_sdin} = {bclk_c, lrclk_c, sdin_c};
            default: {obs_bclk, obs_lrclk, obs_sdin} = {bclk_a, lrclk_a, sdin_a};
        endcase
    end

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Records SDIN/LRCLK at BCLK rising edges; position 0 of the capture lands in the highest bit
    task automatic capture(input int skip, input int nbits, input int budget);
        int   idx  = 0;
        int   left = skip;
        logic prev;
        cap_sd = '0;
        cap_lr = '0;
        prev   = obs_bclk;
        for (int cyc = 0; cyc < budget && idx < nbits; cyc++) begin
            @(negedge clk);
            if (obs_bclk && !prev) begin
                if (left > 0) begin
                    left--;
                end else begin
                    cap_sd = {cap_sd[254:0], obs_sdin};
                    cap_lr = {cap_lr[254:0], obs_lrclk};
                    idx++;
                end
            end
            prev = obs_bclk;
        end
        check("capture_bits", idx, nbits);
    endtask

    int bound;

    initial begin
        rst_n = 1'b0;
        {en_a, mute_a, valid_a, en_b, mute_b, valid_b, en_c, mute_c, valid_c} = '0;
        data_a = '0; data_b = '0; data_c = '0;
        repeat (3) @(negedge clk);

        check("rst_mclk",  mclk_a,  0);
        check("rst_bclk",  bclk_a,  0);
        check("rst_lrclk", lrclk_a, 0);
        check("rst_sdin",  sdin_a,  0);
        check("rst_ready", ready_a, 1);
        check("rst_level", level_a, 0);
        check("rst_urun",  urun_a,  0);

        rst_n = 1'b1;
        @(negedge clk); check("mclk_high", mclk_a, 1);
        @(negedge clk); check("mclk_low",  mclk_a, 0);

        // I2S: L=0x8001, R=0x7FFE
        data_a = 32'h7FFE_8001; valid_a = 1'b1;
        @(negedge clk); valid_a = 1'b0;
        @(negedge clk); check("level_one", level_a, 1);
        en_a = 1'b1;
        capture(1, 64, 1000);
        check("i2s_sdin",  cap_sd[63:0], 64'h4000_8000_3FFF_0000);
        check("i2s_lrclk", cap_lr[63:0], 64'h0000_0000_FFFF_FFFF);
        check("i2s_level", level_a, 0);
        check("i2s_urun",  urun_a, 0);
        en_a = 1'b0;
        @(negedge clk);
        check("dis_bclk",  bclk_a, 0);
        check("dis_lrclk", lrclk_a, 0);

        // Fill FIFO while disabled; fifth push must be dropped
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_a = 32'hFFFF_FFFF;
            @(negedge clk);
            if (i == 2) check("ready_after3", ready_a, 1);
        end
        valid_a = 1'b0;
        @(negedge clk);
        check("full_ready", ready_a, 0);
        check("full_level", level_a, 4);

        // Mute: data suppressed, FIFO still drains one frame per frame period
        mute_a = 1'b1; en_a = 1'b1;
        capture(1, 64, 1000);
        check("mute_sdin1",  cap_sd[63:0], 64'h0);
        check("mute_level1", level_a, 3);
        capture(0, 64, 1000);
        check("mute_sdin2",  cap_sd[63:0], 64'h0);
        check("mute_level2", level_a, 2);
        check("mute_urun",   urun_a, 0);
        mute_a = 1'b0;

        // Asynchronous reset in the right-channel half of a frame
        bound = 0;
        while (!(bclk_a && lrclk_a) && bound < 2000) begin
            @(negedge clk);
            bound++;
        end
        check("mid_frame_reached", bclk_a && lrclk_a, 1);
        rst_n = 1'b0;
        #1;
        check("arst_bclk",  bclk_a,  0);
        check("arst_lrclk", lrclk_a, 0);
        check("arst_sdin",  sdin_a,  0);
        check("arst_mclk",  mclk_a,  0);
        check("arst_level", level_a, 0);
        check("arst_ready", ready_a, 1);
        en_a = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Left-justified on dut_b
        sel = 1;
        data_b = 32'h7FFE_8001; valid_b = 1'b1;
        @(negedge clk); valid_b = 1'b0;
        @(negedge clk);
        en_b = 1'b1;
        capture(1, 64, 400);
        check("lj_sdin",  cap_sd[63:0], 64'h8001_0000_7FFE_0000);
        check("lj_bit0",  cap_sd[63], 1);
        check("lj_lrclk", cap_lr[63:0], 64'h0000_0000_FFFF_FFFF);
        check("lj_urun",  urun_b, 0);
        en_b = 1'b0;
        @(negedge clk);

        // Underrun: empty FIFO sends silence and counts, then saturates
        en_b = 1'b1;
        capture(1, 192, 600);
        check("urun_sdin",  cap_sd[191:0], 192'h0);
        check("urun_three", urun_b, 3);
        repeat (260 * 128) @(negedge clk);
        check("urun_sat", urun_b, 255);
        en_b = 1'b0;

        // Four-channel TDM, I2S framing, two frames (second underruns)
        sel = 2;
        data_c = 64'h00FF_8000_0001_A000; valid_c = 1'b1;
        @(negedge clk); valid_c = 1'b0;
        @(negedge clk);
        en_c = 1'b1;
        capture(1, 128, 600);
        check("tdm_sdin1", cap_sd[127:64], 64'h5000_0000_C000_007F);
        check("tdm_sdin2", cap_sd[63:0],   64'h8000_0000_0000_0000);
        check("tdm_ch2_msb_bit33", cap_sd[127-33], 1);
        check("tdm_lrclk", cap_lr[127:64], 64'h0000_0000_FFFF_FFFF);
        check("tdm_urun",  urun_c, 1);
        en_c = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/i2s_tx_multi.md
# i2s_tx_multi

Parametrised I2S / left-justified serial audio transmitter that generates MCLK, BCLK and LRCLK from the system clock and serialises buffered multi-channel sample frames onto one data line. It sits between the sample source (tone generator or CPU port) and the codec pins (SDIN, BCLK, LRCLK, MCLK). It replaces the fixed 16-bit stereo path with configurable width, slot size, channel count and framing mode, plus an input FIFO and underrun reporting.

## Interface
- DATA_W, 16: sample bits per channel (8..32).
- SLOT_W, 32: BCLK cycles per channel slot; must be ≥ DATA_W.
- NUM_CH, 2: channels per frame; even, 2..8.
- MCLK_HALF, 1: i_clk cycles per MCLK half-period.
- BCLK_HALF, 4: i_clk cycles per BCLK half-period.
- MODE, 0: 0 = I2S (MSB one BCLK after LRCLK edge), 1 = left-justified.
- FIFO_DEPTH, 4: frames buffered; power of two.
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_en  in  1  transmitter enable.
- i_mute  in  1  force all transmitted bits to 0; FIFO still drains.
- i_valid  in  1  frame valid.
- o_ready  out  1  FIFO not full.
- i_data  in  NUM_CH*DATA_W  frame; channel 0 in LSBs.
- o_mclk  out  1  master clock.
- o_bclk  out  1  bit clock.
- o_lrclk  out  1  word select.
- o_sdin  out  1  serial data to codec.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  frames stored.
- o_underrun_cnt  out  8  saturating count of frames sent as silence.

## Operation
- Write: i_valid && o_ready pushes i_data. Push while full is ignored (o_ready low).
- MCLK: free-running toggle every MCLK_HALF cycles whenever reset deasserted, independent of i_en.
- BCLK: when i_en, div counter 0..BCLK_HALF-1; at terminal count o_bclk toggles. i_en low: counter, o_bclk, o_lrclk, o_sdin and bit counter held at 0; re-enable starts at bit 0 of a new frame.
- Bit counter bit_cnt 0..NUM_CH*SLOT_W-1 advances on every BCLK falling-edge event (cycle in which o_bclk goes 1→0), wraps to 0.
- Frame load: at the falling edge that wraps bit_cnt to 0 (and at first falling edge after enable), pop one frame into the shift register if FIFO non-empty; else load zeros and increment o_underrun_cnt (saturate at 255).
- o_lrclk = 1 when bit_cnt ≥ NUM_CH*SLOT_W/2, else 0 (50% duty; NUM_CH>2 gives TDM slots, channels 0..NUM_CH/2-1 in low half).
- Serial stream: slot k carries channel k MSB first for DATA_W bits, then SLOT_W-DATA_W zeros.
- MODE 1: o_sdin = stream bit bit_cnt. MODE 0: o_sdin = stream bit bit_cnt-1; bit position 0 carries previous frame's final bit.
- i_mute forces o_sdin = 0 without affecting FIFO pops or counters.
- Simultaneous push and pop: level unchanged; push into full FIFO during same-cycle pop accepted only if o_ready was high (o_ready is registered from level, no bypass).

## Timing
- Reset values: o_mclk 0, o_bclk 0, o_lrclk 0, o_sdin 0, o_ready 1, o_fifo_level 0, o_underrun_cnt 0, FIFO pointers 0.
- o_bclk, o_lrclk, o_sdin all registered; o_lrclk and o_sdin change in the same i_clk cycle as o_bclk falling, stable through the rising edge.
- o_fifo_level updates the cycle after push/pop; o_ready = (level != FIFO_DEPTH) registered.
- BCLK period = 2*BCLK_HALF i_clk cycles; frame = NUM_CH*SLOT_W BCLK periods.
- Reset mid-frame: all outputs return to reset values asynchronously; FIFO content discarded.
- i_en deassert mid-frame: current frame abandoned, not re-sent.

## Structure
- Package i2s_pkg: mode constants (I2S_MODE_I2S=0, I2S_MODE_LJ=1), parameter legality checks as localparams.
- Sub-module i2s_frame_fifo: synchronous FIFO, width NUM_CH*DATA_W, depth FIFO_DEPTH, level output.
- Top holds clock dividers, bit counter, shift register and underrun counter.

## Test plan
- Defaults, MODE 0, push L=0x8001 R=0x7FFE then enable → LRCLK low 32 BCLKs; SDIN bit1=1, bits2..15=0, bit16=1, bits17..31=0; right slot 0111…10 starting bit33.
- MODE 1, same frame → MSB of L on bit_cnt 0, MSB of R on bit_cnt 32.
- Empty FIFO, enable 3 frames → SDIN all 0, o_underrun_cnt = 3; 300 frames → saturates at 255.
- Push 5 frames with FIFO_DEPTH 4, i_en low → o_ready low after 4, level 4, 5th ignored.
- NUM_CH=4, SLOT_W=16, DATA_W=16 → LRCLK high from bit 32 to 63; channel 2 MSB at bit 33 (MODE 0).
- Assert i_rst_n low mid-frame → all outputs 0 immediately, level 0, o_ready 1; i_mute high → SDIN 0 while level decrements once per frame.
